ace_ccu_snoop_scheduler: RTL and testbench
==========================================

Name: ace_ccu_snoop_scheduler

Overview:
Front-end controller for the CCU snoop interconnect. It accepts snoop requests from NumMst requesters (one per ACE master port), arbitrates between them round-robin, and generates the per-port snoop select mask, which covers every enabled port except the initiator. It issues one AC request per cycle toward the interconnect and tracks outstanding snoops in a tag table, so that two snoops to the same cache line are never in flight at once.

Parameters:
NumMst, 4, number of requesters and snooped ports; requester i is master port i.
AddrWidth, 64, snoop address width.
LineBytes, 64, cache line size in bytes (power of 2); used for hazard comparison.
MaxOut, 8, number of outstanding snoop table entries (≥2).
TagWidth, $clog2(MaxOut), width of the table tag.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
snp_en_i  in  NumMst  static config: port i may be snooped
req_valid_i  in  NumMst  requester i has a snoop request
req_ready_o  out  NumMst  request i accepted this cycle
req_addr_i  in  NumMst*AddrWidth  request address per requester
req_snoop_i  in  NumMst*4  AC snoop type per requester
ac_valid_o  out  1  issued snoop valid
ac_ready_i  in  1  interconnect accepts issued snoop
ac_addr_o  out  AddrWidth  issued address
ac_snoop_o  out  4  issued snoop type
ac_sel_o  out  NumMst  ports to snoop (feeds the interconnect input-select)
ac_src_o  out  $clog2(NumMst)  initiating requester index
ac_tag_o  out  TagWidth  table entry allocated to this snoop
cmpl_valid_i  in  1  snoop with tag cmpl_tag_i fully completed (all CR/CD received)
cmpl_tag_i  in  TagWidth  completed tag
outstanding_o  out  $clog2(MaxOut+1)  number of valid table entries
err_o  out  1  sticky: completion arrived for a free tag

Behaviour:
- Reset (rst_n=1, asynchronous): ac_valid_o=0, all AC payload outputs=0, table entries all free, outstanding_o=0, err_o=0, RR pointer=0. req_ready_o=0 while in reset.
- Line address = addr >> log2(LineBytes).
- Sel mask for requester i = snp_en_i with bit i cleared.
- Eligibility: requester i is eligible when all of the following hold:
  - req_valid_i[i]=1.
  - Its line matches no valid table entry (registered state) and no snoop currently held in the output register.
  - Either its sel mask is zero, or a free entry exists and the output register is empty or draining this cycle (ac_valid_o & ac_ready_i).
- Grant: at most one requester per cycle. Round-robin starts at the RR pointer. On grant, the pointer moves to granted+1 (wraps at NumMst). req_ready_o is combinational, one-hot, = grant.
- Null snoop (sel mask = 0): the request is accepted, no entry is allocated, no AC is issued, and the RR pointer still advances.
- Normal grant:
  - Allocate the lowest-index free entry and store its line.
  - Load the output register.
  - Next cycle: ac_valid_o=1. Latency request handshake to ac_valid_o is exactly 1 cycle.
- Output register: payload is stable while ac_valid_o & !ac_ready_i. Back-to-back issue is allowed, so a new grant may load in the cycle the old snoop drains.
- Completion: when cmpl_valid_i=1, the entry for cmpl_tag_i is freed at the clock edge. A request to the same line is eligible from the next cycle (hazard check uses registered state).
- Completion for a free tag: ignored, and err_o is set (sticky until reset).
- outstanding_o: incremented on allocation, decremented on valid completion. A same-cycle allocation and completion leave it unchanged.
- Full table (outstanding_o=MaxOut): non-null requests are stalled; null snoops are still accepted.
- A snoop's entry stays valid from allocation until completion, including while it waits in the output register.
- Reset mid-operation: all state clears and any pending ac_valid_o drops immediately; completions of pre-reset tags afterwards raise err_o.

Test Plan:
- Single request: req 0, addr 0x1000, snp_en_i=4'b1111 → 1 cycle later ac_valid_o=1, ac_sel_o=4'b1110, ac_src_o=0, ac_tag_o=0; after cmpl tag 0, outstanding_o returns 0.
- Fairness: all four requesters hold distinct lines continuously with ac_ready_i=1 → grants rotate 0,1,2,3,0…; no requester is starved for more than 3 consecutive grants.
- Hazard: req 1 to 0x2000 issued (tag 0); req 2 to 0x2020 (same 64B line) stalls, req_ready_o[2]=0, until cmpl tag 0 → req 2 granted the cycle after completion.
- Full table: MaxOut=8 distinct requests issued without completion → outstanding_o=8, further requests stall; one completion of tag 3 → next grant uses tag 3.
- Null snoop and backpressure: snp_en_i=4'b0001, req 0 → accepted, no ac_valid_o; then snp_en_i=1111, ac_ready_i=0 for 5 cycles → payload stable, a second grant occurs only in the drain cycle.
- Error/reset: cmpl_valid_i with a free tag 5 → err_o=1 (sticky); assert rst_n mid-burst → ac_valid_o=0, outstanding_o=0, err_o=0.

Source files
------------

// File: rtl/ace_ccu_snoop_scheduler_if.sv
// Snoop scheduler bus bundle: requester side, issued AC channel and completion return.
interface ace_ccu_snoop_scheduler_if #(
  parameter int unsigned NumMst    = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned MaxOut    = 8,
  parameter int unsigned TagWidth  = $clog2(MaxOut)
);
  localparam int unsigned SrcW = $clog2(NumMst);

  logic [NumMst-1:0]           req_valid_i;
  logic [NumMst-1:0]           req_ready_o;
  logic [NumMst*AddrWidth-1:0] req_addr_i;
  logic [NumMst*4-1:0]         req_snoop_i;

  logic                        ac_valid_o;
  logic                        ac_ready_i;
  logic [AddrWidth-1:0]        ac_addr_o;
  logic [3:0]                  ac_snoop_o;
  logic [NumMst-1:0]           ac_sel_o;
  logic [SrcW-1:0]             ac_src_o;
  logic [TagWidth-1:0]         ac_tag_o;

  logic                        cmpl_valid_i;
  logic [TagWidth-1:0]         cmpl_tag_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_snoop_i, ac_ready_i, cmpl_valid_i, cmpl_tag_i,
    output req_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, ac_sel_o, ac_src_o, ac_tag_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_snoop_i, ac_ready_i, cmpl_valid_i, cmpl_tag_i,
    input  req_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, ac_sel_o, ac_src_o, ac_tag_o
  );
endinterface

// File: rtl/ace_ccu_snoop_scheduler.sv
// Round-robin snoop request scheduler with a line-address tag table that
// prevents two snoops to the same cache line from being in flight together.
module ace_ccu_snoop_scheduler #(
  parameter int unsigned NumMst    = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineBytes = 64,
  parameter int unsigned MaxOut    = 8,
  parameter int unsigned TagWidth  = $clog2(MaxOut)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NumMst-1:0]            snp_en_i,
  ace_ccu_snoop_scheduler_if.slave     bus,
  output logic [$clog2(MaxOut+1)-1:0]  outstanding_o,
  output logic                         err_o
);
  localparam int unsigned OffW  = $clog2(LineBytes);
  localparam int unsigned LineW = AddrWidth - OffW;
  localparam int unsigned SrcW  = $clog2(NumMst);
  localparam int unsigned CntW  = $clog2(MaxOut+1);

  logic [MaxOut-1:0]            valid_q, valid_d;
  logic [MaxOut-1:0][LineW-1:0] line_q, line_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic [SrcW-1:0]              rr_q, rr_d;
  logic                         ac_valid_q, ac_valid_d;
  logic [AddrWidth-1:0]         ac_addr_q, ac_addr_d;
  logic [3:0]                   ac_snoop_q, ac_snoop_d;
  logic [NumMst-1:0]            ac_sel_q, ac_sel_d;
  logic [SrcW-1:0]              ac_src_q, ac_src_d;
  logic [TagWidth-1:0]          ac_tag_q, ac_tag_d;

  logic [NumMst-1:0][AddrWidth-1:0] req_addr;
  logic [NumMst-1:0][3:0]           req_snoop;
  logic [NumMst-1:0][LineW-1:0]     req_line;
  logic [NumMst-1:0][NumMst-1:0]    req_sel;
  logic [NumMst-1:0]                hazard, elig, gnt;
  logic                             free_any, gnt_any, out_avail, alloc, cmpl_ok;
  logic [TagWidth-1:0]              free_idx;
  logic [SrcW-1:0]                  gnt_idx, idx;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned e = 0; e < MaxOut; e++) begin
      if (!valid_q[e] && !free_any) begin
        free_any = 1'b1;
        free_idx = TagWidth'(e);
      end
    end
    out_avail = !ac_valid_q || bus.ac_ready_i;

    // A queued snoop keeps its table entry, so the table check also covers the output register.
    req_addr  = '0;
    req_snoop = '0;
    req_line  = '0;
    req_sel   = '0;
    hazard    = '0;
    elig      = '0;
    for (int unsigned i = 0; i < NumMst; i++) begin
      req_addr[i]   = bus.req_addr_i[i*AddrWidth +: AddrWidth];
      req_snoop[i]  = bus.req_snoop_i[i*4 +: 4];
      req_line[i]   = req_addr[i][AddrWidth-1:OffW];
      req_sel[i]    = snp_en_i;
      req_sel[i][i] = 1'b0;
      for (int unsigned e = 0; e < MaxOut; e++) begin
        if (valid_q[e] && (line_q[e] == req_line[i])) hazard[i] = 1'b1;
      end
      elig[i] = bus.req_valid_i[i] && !hazard[i] &&
                ((req_sel[i] == '0) || (free_any && out_avail));
    end

    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NumMst; k++) begin
      idx = SrcW'((32'(rr_q) + k) % NumMst);
      if (elig[idx] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    alloc   = gnt_any && (req_sel[gnt_idx] != '0);
    cmpl_ok = bus.cmpl_valid_i && valid_q[bus.cmpl_tag_i];

    valid_d = valid_q;
    line_d  = line_q;
    if (cmpl_ok) valid_d[bus.cmpl_tag_i] = 1'b0;
    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      line_d[free_idx]  = req_line[gnt_idx];
    end
    cnt_d = cnt_q + CntW'(alloc) - CntW'(cmpl_ok);
    err_d = err_q || (bus.cmpl_valid_i && !cmpl_ok);

    rr_d = rr_q;
    if (gnt_any) rr_d = (gnt_idx == SrcW'(NumMst-1)) ? '0 : gnt_idx + SrcW'(1);

    ac_valid_d = ac_valid_q;
    ac_addr_d  = ac_addr_q;
    ac_snoop_d = ac_snoop_q;
    ac_sel_d   = ac_sel_q;
    ac_src_d   = ac_src_q;
    ac_tag_d   = ac_tag_q;
    if (alloc) begin
      ac_valid_d = 1'b1;
      ac_addr_d  = req_addr[gnt_idx];
      ac_snoop_d = req_snoop[gnt_idx];
      ac_sel_d   = req_sel[gnt_idx];
      ac_src_d   = gnt_idx;
      ac_tag_d   = free_idx;
    end else if (bus.ac_ready_i) begin
      ac_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q    <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rr_q       <= '0;
      ac_valid_q <= 1'b0;
      ac_addr_q  <= '0;
      ac_snoop_q <= '0;
      ac_sel_q   <= '0;
      ac_src_q   <= '0;
      ac_tag_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rr_q       <= rr_d;
      ac_valid_q <= ac_valid_d;
      ac_addr_q  <= ac_addr_d;
      ac_snoop_q <= ac_snoop_d;
      ac_sel_q   <= ac_sel_d;
      ac_src_q   <= ac_src_d;
      ac_tag_q   <= ac_tag_d;
    end
  end

  assign bus.req_ready_o = rst_n ? '0 : gnt;
  assign bus.ac_valid_o  = ac_valid_q;
  assign bus.ac_addr_o   = ac_addr_q;
  assign bus.ac_snoop_o  = ac_snoop_q;
  assign bus.ac_sel_o    = ac_sel_q;
  assign bus.ac_src_o    = ac_src_q;
  assign bus.ac_tag_o    = ac_tag_q;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_ace_ccu_snoop_scheduler.sv
// Directed bench for the snoop scheduler: arbitration, hazards, table limits and reset.
module tb_ace_ccu_snoop_scheduler;
  localparam int unsigned NumMst    = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned LineBytes = 64;
  localparam int unsigned MaxOut    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] snp_en;
  logic [3:0] outstanding;
  logic       err;
  int vectors = 0;
  int miscompares = 0;

  ace_ccu_snoop_scheduler_if #(.NumMst(NumMst), .AddrWidth(AddrWidth), .MaxOut(MaxOut)) bus ();

  ace_ccu_snoop_scheduler #(
    .NumMst(NumMst), .AddrWidth(AddrWidth), .LineBytes(LineBytes), .MaxOut(MaxOut)
  ) dut (
    .clk(clk), .rst_n(rst_n), .snp_en_i(snp_en), .bus(bus),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] addr);
    bus.req_addr_i[i*64 +: 64] = addr;
    bus.req_snoop_i[i*4 +: 4]  = 4'(i + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    snp_en = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, 64'h100 * (i + 1));
    bus.req_valid_i = 4'hF;
    bus.ac_ready_i = 1'b1;
    bus.cmpl_valid_i = 1'b0;
    bus.cmpl_tag_i = '0;
    tick(); tick();
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready_o); end
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_ac_valid: got %b exp 0", bus.ac_valid_o); end
    vectors++; if (bus.ac_addr_o !== 64'h0) begin miscompares++; $display("FAIL reset_ac_addr: got %h exp 0", bus.ac_addr_o); end
    vectors++; if (bus.ac_sel_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ac_sel: got %b exp 0000", bus.ac_sel_o); end
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", err); end
    bus.req_valid_i = 4'b0000;
    rst_n = 1'b0;
    tick();
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_ac_valid: got %b exp 0", bus.ac_valid_o); end
  endtask

  task automatic test_single();
    set_req(0, 64'h1000);
    bus.req_valid_i = 4'b0001;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b exp 0001", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    vectors++; if (bus.ac_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_ac_valid: got %b exp 1", bus.ac_valid_o); end
    vectors++; if (bus.ac_sel_o !== 4'b1110) begin miscompares++; $display("FAIL single_sel: got %b exp 1110", bus.ac_sel_o); end
    vectors++; if (bus.ac_src_o !== 2'd0) begin miscompares++; $display("FAIL single_src: got %0d exp 0", bus.ac_src_o); end
    vectors++; if (bus.ac_tag_o !== 3'd0) begin miscompares++; $display("FAIL single_tag: got %0d exp 0", bus.ac_tag_o); end
    vectors++; if (bus.ac_addr_o !== 64'h1000) begin miscompares++; $display("FAIL single_addr: got %h exp 1000", bus.ac_addr_o); end
    vectors++; if (bus.ac_snoop_o !== 4'h1) begin miscompares++; $display("FAIL single_snoop: got %h exp 1", bus.ac_snoop_o); end
    vectors++; if (outstanding !== 4'd1) begin miscompares++; $display("FAIL single_outstanding: got %0d exp 1", outstanding); end
    tick();
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %b exp 0", bus.ac_valid_o); end
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd0;
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL single_cmpl_outstanding: got %0d exp 0", outstanding); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b exp 0", err); end
  endtask

  // RR pointer is 1 on entry (last grant was requester 0); each snoop completes the cycle it is shown.
  task automatic test_fairness();
    int g;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) set_req(i, 64'h10000 + 64'h100 * i + 64'h1000 * k);
      bus.req_valid_i = 4'hF;
      bus.cmpl_valid_i = (k > 0);
      bus.cmpl_tag_i = 3'((k + 1) % 2);
      #1;
      g = (1 + k) % 4;
      vectors++; if (bus.req_ready_o !== (4'b0001 << g)) begin miscompares++; $display("FAIL rr_grant k=%0d: got %b exp %b", k, bus.req_ready_o, 4'b0001 << g); end
      if (k > 0) begin
        vectors++; if (bus.ac_src_o !== 2'(k % 4)) begin miscompares++; $display("FAIL rr_src k=%0d: got %0d exp %0d", k, bus.ac_src_o, k % 4); end
        vectors++; if (bus.ac_tag_o !== 3'((k + 1) % 2)) begin miscompares++; $display("FAIL rr_tag k=%0d: got %0d exp %0d", k, bus.ac_tag_o, (k + 1) % 2); end
        vectors++; if (outstanding !== 4'd1) begin miscompares++; $display("FAIL rr_outstanding k=%0d: got %0d exp 1", k, outstanding); end
      end
      tick();
    end
    bus.req_valid_i = 4'b0000;
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd1;
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL rr_drain_outstanding: got %0d exp 0", outstanding); end
  endtask

  task automatic test_hazard();
    set_req(1, 64'h2000);
    bus.req_valid_i = 4'b0010;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL hz_first_grant: got %b exp 0010", bus.req_ready_o); end
    tick();
    set_req(2, 64'h2020);
    bus.req_valid_i = 4'b0100;
    #1;
    vectors++; if (bus.ac_tag_o !== 3'd0) begin miscompares++; $display("FAIL hz_first_tag: got %0d exp 0", bus.ac_tag_o); end
    vectors++; if (bus.ac_src_o !== 2'd1) begin miscompares++; $display("FAIL hz_first_src: got %0d exp 1", bus.ac_src_o); end
    for (int c = 0; c < 3; c++) begin
      vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL hz_stall c=%0d: got %b exp 0000", c, bus.req_ready_o); end
      tick();
    end
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd0;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL hz_stall_cmpl_cycle: got %b exp 0000", bus.req_ready_o); end
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL hz_release: got %b exp 0100", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    vectors++; if (bus.ac_src_o !== 2'd2) begin miscompares++; $display("FAIL hz_second_src: got %0d exp 2", bus.ac_src_o); end
    vectors++; if (bus.ac_tag_o !== 3'd0) begin miscompares++; $display("FAIL hz_second_tag: got %0d exp 0", bus.ac_tag_o); end
    vectors++; if (bus.ac_addr_o !== 64'h2020) begin miscompares++; $display("FAIL hz_second_addr: got %h exp 2020", bus.ac_addr_o); end
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd0;
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL hz_outstanding: got %0d exp 0", outstanding); end
  endtask

  task automatic test_full_table();
    bus.req_valid_i = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      set_req(3, 64'h40000 + 64'h40 * k);
      #1;
      vectors++; if (bus.req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL full_fill_grant k=%0d: got %b exp 1000", k, bus.req_ready_o); end
      if (k > 0) begin
        vectors++; if (bus.ac_tag_o !== 3'(k - 1)) begin miscompares++; $display("FAIL full_fill_tag k=%0d: got %0d exp %0d", k, bus.ac_tag_o, k - 1); end
      end
      tick();
    end
    set_req(3, 64'h40200);
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL full_stall: got %b exp 0000", bus.req_ready_o); end
    vectors++; if (outstanding !== 4'd8) begin miscompares++; $display("FAIL full_outstanding: got %0d exp 8", outstanding); end
    vectors++; if (bus.ac_tag_o !== 3'd7) begin miscompares++; $display("FAIL full_last_tag: got %0d exp 7", bus.ac_tag_o); end
    snp_en = 4'b1000;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL full_null_accept: got %b exp 1000", bus.req_ready_o); end
    tick();
    snp_en = 4'hF;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL full_stall2: got %b exp 0000", bus.req_ready_o); end
    vectors++; if (outstanding !== 4'd8) begin miscompares++; $display("FAIL full_null_no_alloc: got %0d exp 8", outstanding); end
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd3;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL full_stall_cmpl_cycle: got %b exp 0000", bus.req_ready_o); end
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL full_regrant: got %b exp 1000", bus.req_ready_o); end
    vectors++; if (outstanding !== 4'd7) begin miscompares++; $display("FAIL full_after_cmpl: got %0d exp 7", outstanding); end
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    vectors++; if (bus.ac_tag_o !== 3'd3) begin miscompares++; $display("FAIL full_reuse_tag: got %0d exp 3", bus.ac_tag_o); end
    vectors++; if (bus.ac_addr_o !== 64'h40200) begin miscompares++; $display("FAIL full_reuse_addr: got %h exp 40200", bus.ac_addr_o); end
    vectors++; if (outstanding !== 4'd8) begin miscompares++; $display("FAIL full_refill: got %0d exp 8", outstanding); end
    for (int t = 0; t < 8; t++) begin
      bus.cmpl_valid_i = 1'b1;
      bus.cmpl_tag_i = 3'(t);
      tick();
    end
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL full_drain: got %0d exp 0", outstanding); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL full_err: got %b exp 0", err); end
  endtask

  task automatic test_null_backpressure();
    snp_en = 4'b0001;
    set_req(0, 64'h5000);
    bus.req_valid_i = 4'b0001;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL null_accept: got %b exp 0001", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL null_no_ac: got %b exp 0", bus.ac_valid_o); end
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL null_no_alloc: got %0d exp 0", outstanding); end
    snp_en = 4'hF;
    bus.ac_ready_i = 1'b0;
    set_req(0, 64'h6000);
    bus.req_valid_i = 4'b0001;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL bp_first_grant: got %b exp 0001", bus.req_ready_o); end
    tick();
    set_req(1, 64'h7000);
    bus.req_valid_i = 4'b0010;
    #1;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.ac_valid_o !== 1'b1 || bus.ac_addr_o !== 64'h6000) begin miscompares++; $display("FAIL bp_hold c=%0d: got v=%b a=%h exp v=1 a=6000", c, bus.ac_valid_o, bus.ac_addr_o); end
      vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL bp_stall c=%0d: got %b exp 0000", c, bus.req_ready_o); end
      tick();
    end
    bus.ac_ready_i = 1'b1;
    #1;
    vectors++; if (bus.req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL bp_drain_grant: got %b exp 0010", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    vectors++; if (bus.ac_valid_o !== 1'b1 || bus.ac_addr_o !== 64'h7000) begin miscompares++; $display("FAIL bp_b2b: got v=%b a=%h exp v=1 a=7000", bus.ac_valid_o, bus.ac_addr_o); end
    vectors++; if (bus.ac_src_o !== 2'd1 || bus.ac_tag_o !== 3'd1) begin miscompares++; $display("FAIL bp_b2b_id: got src=%0d tag=%0d exp src=1 tag=1", bus.ac_src_o, bus.ac_tag_o); end
    vectors++; if (outstanding !== 4'd2) begin miscompares++; $display("FAIL bp_outstanding: got %0d exp 2", outstanding); end
    tick();
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %b exp 0", bus.ac_valid_o); end
    for (int t = 0; t < 2; t++) begin
      bus.cmpl_valid_i = 1'b1;
      bus.cmpl_tag_i = 3'(t);
      tick();
    end
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL bp_drain: got %0d exp 0", outstanding); end
  endtask

  task automatic test_error_reset();
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd5;
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_before_edge: got %b exp 0", err); end
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b exp 1", err); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b exp 1", err); end
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL err_outstanding: got %0d exp 0", outstanding); end
    for (int i = 0; i < 4; i++) set_req(i, 64'h80000 + 64'h1000 * i);
    bus.req_valid_i = 4'hF;
    #1;
    tick();
    tick();
    vectors++; if (outstanding !== 4'd2 || bus.ac_valid_o !== 1'b1 || bus.ac_src_o !== 2'd3) begin miscompares++; $display("FAIL burst: got out=%0d v=%b src=%0d exp out=2 v=1 src=3", outstanding, bus.ac_valid_o, bus.ac_src_o); end
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.ac_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_ac_valid: got %b exp 0", bus.ac_valid_o); end
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL midrst_outstanding: got %0d exp 0", outstanding); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b exp 0", err); end
    vectors++; if (bus.req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL midrst_ready: got %b exp 0000", bus.req_ready_o); end
    tick();
    rst_n = 1'b0;
    bus.req_valid_i = 4'b0000;
    tick();
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i = 3'd0;
    tick();
    bus.cmpl_valid_i = 1'b0;
    #1;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stale_cmpl_err: got %b exp 1", err); end
    vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL stale_cmpl_outstanding: got %0d exp 0", outstanding); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    snp_en = 4'hF;
    bus.req_valid_i = '0;
    bus.req_addr_i = '0;
    bus.req_snoop_i = '0;
    bus.ac_ready_i = 1'b1;
    bus.cmpl_valid_i = 1'b0;
    bus.cmpl_tag_i = '0;
    test_reset();
    test_single();
    test_fairness();
    test_hazard();
    test_full_table();
    test_null_backpressure();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
